// File: rtl/ring_upload_pkg.sv
// ---------------------------------------------------------------------------
// ring_upload_pkg : flit control codes and upload state type.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ring_upload_pkg;

    localparam logic [1:0] CTRL_HEAD = 2'b01;
    localparam logic [1:0] CTRL_BODY = 2'b10;
    localparam logic [1:0] CTRL_TAIL = 2'b11;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/upload_msg_fifo.sv
// ---------------------------------------------------------------------------
// upload_msg_fifo : synchronous {len, data} message queue, full/empty flags.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module upload_msg_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);

endmodule

`default_nettype wire

// File: rtl/flit_upload_gen.sv
// ---------------------------------------------------------------------------
// flit_upload_gen : splits queued messages into head/body/tail flits.
// Build option FLIT_UPLOAD_LEN_CHECK_EN adds length check and len_err. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module flit_upload_gen
    import ring_upload_pkg::*;
#(
    parameter int FLIT_W    = 16,
    parameter int MAX_FLITS = 3,
    parameter int DEPTH     = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [MAX_FLITS*FLIT_W-1:0]        msg_in,
    input  logic [$clog2(MAX_FLITS+1)-1:0]     msg_len,
    input  logic                               v_msg_in,
    output logic                               msg_rdy,
    input  logic                               fifo_rdy,
    output logic [FLIT_W-1:0]                  flit_out,
    output logic                               v_flit_out,
    output logic [1:0]                         ctrl_out,
    output logic                               upload_state
`ifdef FLIT_UPLOAD_LEN_CHECK_EN
    ,
    output logic                               len_err
`endif
);

    localparam int LEN_W = $clog2(MAX_FLITS+1);
    localparam int MSG_W = MAX_FLITS*FLIT_W;

    state_t             state;
    state_t             state_nx;
    logic [MSG_W-1:0]   cur_msg;
    logic [LEN_W-1:0]   cur_len;
    logic [LEN_W-1:0]   idx;
    logic [LEN_W+MSG_W-1:0] q_rd;
    logic               q_full;
    logic               q_empty;
    logic               len_ok;
    logic               accept;
    logic               bypass;
    logic               enq;
    logic               deq;
    logic               consume;
    logic               tail;

`ifdef FLIT_UPLOAD_LEN_CHECK_EN
    assign len_ok = (msg_len != '0) && (msg_len <= LEN_W'(MAX_FLITS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            len_err <= 1'b0;
        else if (v_msg_in && msg_rdy && !len_ok)
            len_err <= 1'b1;
    end
`else
    assign len_ok = 1'b1;
`endif

    assign msg_rdy = !q_full;
    assign accept  = v_msg_in && msg_rdy && len_ok;
    assign consume = (state == BUSY) && fifo_rdy;
    assign tail    = (idx == cur_len - 1'b1);
    assign bypass  = accept && (state == IDLE) && q_empty;
    assign enq     = accept && !bypass;
    // The next queued message loads on tail consumption, or as soon as the block is idle.
    assign deq     = !q_empty && ((state == IDLE) || (consume && tail));

    upload_msg_fifo #(
        .WIDTH (LEN_W+MSG_W),
        .DEPTH (DEPTH)
    ) u_msg_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (enq),
        .wr_data ({msg_len, msg_in}),
        .rd_en   (deq),
        .rd_data (q_rd),
        .full    (q_full),
        .empty   (q_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bypass || !q_empty) state_nx = BUSY;
            BUSY:    if (consume && tail && q_empty) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_msg <= '0;
            cur_len <= '0;
            idx     <= '0;
        end else if (bypass) begin
            cur_msg <= msg_in;
            cur_len <= msg_len;
            idx     <= '0;
        end else if (deq) begin
            cur_msg <= q_rd[MSG_W-1:0];
            cur_len <= q_rd[LEN_W+MSG_W-1 -: LEN_W];
            idx     <= '0;
        end else if (consume) begin
            idx     <= tail ? '0 : idx + 1'b1;
        end
    end

    always_comb begin
        flit_out = '0;
        ctrl_out = CTRL_HEAD;
        if (state == BUSY) begin
            for (int k = 0; k < MAX_FLITS; k++) begin
                if (idx == LEN_W'(k)) flit_out = cur_msg[(MAX_FLITS-1-k)*FLIT_W +: FLIT_W];
            end
            if (tail)            ctrl_out = CTRL_TAIL;
            else if (idx == '0)  ctrl_out = CTRL_HEAD;
            else                 ctrl_out = CTRL_BODY;
        end
    end

    assign upload_state = (state == BUSY);
    assign v_flit_out   = upload_state && fifo_rdy;

endmodule

`default_nettype wire

// File: tb/tb_flit_upload_gen.sv
// ---------------------------------------------------------------------------
// tb_flit_upload_gen : directed self-checking bench for flit_upload_gen. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_flit_upload_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] msg_in;
    logic [1:0]  msg_len;
    logic        v_msg_in;
    logic        msg_rdy;
    logic        fifo_rdy;
    logic [15:0] flit_out;
    logic        v_flit_out;
    logic [1:0]  ctrl_out;
    logic        upload_state;
`ifdef FLIT_UPLOAD_LEN_CHECK_EN
    logic        len_err;
`endif

    int vectors = 0;
    int miscompares = 0;

    // {flit, ctrl, v_flit_out, upload_state, msg_rdy}
    logic [20:0] obs;
    localparam logic [20:0] IDLE_O = {16'h0000, 2'b01, 1'b0, 1'b0, 1'b1};

    assign obs = {flit_out, ctrl_out, v_flit_out, upload_state, msg_rdy};

    flit_upload_gen #(.FLIT_W(16), .MAX_FLITS(3), .DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .msg_in       (msg_in),
        .msg_len      (msg_len),
        .v_msg_in     (v_msg_in),
        .msg_rdy      (msg_rdy),
        .fifo_rdy     (fifo_rdy),
        .flit_out     (flit_out),
        .v_flit_out   (v_flit_out),
        .ctrl_out     (ctrl_out),
        .upload_state (upload_state)
`ifdef FLIT_UPLOAD_LEN_CHECK_EN
        ,
        .len_err      (len_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; fifo_rdy = 1'b1; v_msg_in = 1'b1;
        msg_in = 48'h111122223333; msg_len = 2'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (obs !== IDLE_O) begin
                miscompares++;
                $display("FAIL reset[%0d]: got %h expected %h", i, obs, IDLE_O);
            end
            step();
        end
        v_msg_in = 1'b0;
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [20:0] exp_o [4] = '{
            {16'h1234, 2'b01, 1'b1, 1'b1, 1'b1},
            {16'h5678, 2'b10, 1'b1, 1'b1, 1'b1},
            {16'habcd, 2'b11, 1'b1, 1'b1, 1'b1},
            IDLE_O };
        fifo_rdy = 1'b1; msg_in = 48'h12345678abcd; msg_len = 2'd3; v_msg_in = 1'b1;
        step();
        v_msg_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (obs !== exp_o[i]) begin
                miscompares++;
                $display("FAIL basic[%0d]: got %h expected %h", i, obs, exp_o[i]);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic        fr [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [20:0] exp_o [6] = '{
            {16'hc0de, 2'b01, 1'b1, 1'b1, 1'b1},
            {16'h2016, 2'b10, 1'b0, 1'b1, 1'b1},
            {16'h2016, 2'b10, 1'b0, 1'b1, 1'b1},
            {16'h2016, 2'b10, 1'b1, 1'b1, 1'b1},
            {16'hc0de, 2'b11, 1'b1, 1'b1, 1'b1},
            IDLE_O };
        fifo_rdy = 1'b1; msg_in = 48'hc0de2016c0de; msg_len = 2'd3; v_msg_in = 1'b1;
        step();
        v_msg_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            fifo_rdy = fr[i];
            #1;
            vectors++;
            if (obs !== exp_o[i]) begin
                miscompares++;
                $display("FAIL backpressure[%0d]: got %h expected %h", i, obs, exp_o[i]);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [20:0] exp_o [7] = '{
            {16'h1111, 2'b01, 1'b1, 1'b1, 1'b1},
            {16'h2222, 2'b10, 1'b1, 1'b1, 1'b1},
            {16'h3333, 2'b11, 1'b1, 1'b1, 1'b1},
            {16'h4444, 2'b01, 1'b1, 1'b1, 1'b1},
            {16'h5555, 2'b10, 1'b1, 1'b1, 1'b1},
            {16'h6666, 2'b11, 1'b1, 1'b1, 1'b1},
            IDLE_O };
        fifo_rdy = 1'b1; msg_in = 48'h111122223333; msg_len = 2'd3; v_msg_in = 1'b1;
        step();
        msg_in = 48'h444455556666;
        for (int i = 0; i < 7; i++) begin
            v_msg_in = (i == 0);
            #1;
            vectors++;
            if (obs !== exp_o[i]) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, obs, exp_o[i]);
            end
            step();
        end
    endtask

    // First message bypasses into the sender; the next DEPTH fill the queue, the last is dropped.
    task automatic test_full_queue();
        logic        vin [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        fr  [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [47:0] msg [10] = '{48'hb0b0b1b10000, 48'hc0c0c1c10000, 48'hd0d0d1d10000,
                                  48'h0, 48'h0, 48'h0, 48'h0, 48'h0, 48'h0, 48'h0};
        logic [20:0] exp_o [10] = '{
            {16'ha0a0, 2'b01, 1'b0, 1'b1, 1'b1},
            {16'ha0a0, 2'b01, 1'b0, 1'b1, 1'b1},
            {16'ha0a0, 2'b01, 1'b0, 1'b1, 1'b0},
            {16'ha0a0, 2'b01, 1'b1, 1'b1, 1'b0},
            {16'ha1a1, 2'b11, 1'b1, 1'b1, 1'b0},
            {16'hb0b0, 2'b01, 1'b1, 1'b1, 1'b1},
            {16'hb1b1, 2'b11, 1'b1, 1'b1, 1'b1},
            {16'hc0c0, 2'b01, 1'b1, 1'b1, 1'b1},
            {16'hc1c1, 2'b11, 1'b1, 1'b1, 1'b1},
            IDLE_O };
        fifo_rdy = 1'b0; msg_in = 48'ha0a0a1a10000; msg_len = 2'd2; v_msg_in = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            v_msg_in = vin[i]; fifo_rdy = fr[i]; msg_in = msg[i];
            #1;
            vectors++;
            if (obs !== exp_o[i]) begin
                miscompares++;
                $display("FAIL full_queue[%0d]: got %h expected %h", i, obs, exp_o[i]);
            end
            step();
        end
    endtask

    task automatic test_short();
        logic [20:0] exp_o [2] = '{ {16'hbeef, 2'b11, 1'b1, 1'b1, 1'b1}, IDLE_O };
        fifo_rdy = 1'b1; msg_in = 48'hbeef00000000; msg_len = 2'd1; v_msg_in = 1'b1;
        step();
        v_msg_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if (obs !== exp_o[i]) begin
                miscompares++;
                $display("FAIL short[%0d]: got %h expected %h", i, obs, exp_o[i]);
            end
            step();
        end
    endtask

    // Reset lands mid-body with two messages queued; nothing of them may survive.
    task automatic test_reset_mid_message();
        logic        vin [3] = '{1'b1, 1'b1, 1'b0};
        logic        fr  [3] = '{1'b1, 1'b0, 1'b0};
        logic [20:0] exp_o [9] = '{
            {16'h0102, 2'b01, 1'b1, 1'b1, 1'b1},
            {16'h0304, 2'b10, 1'b0, 1'b1, 1'b1},
            {16'h0304, 2'b10, 1'b0, 1'b1, 1'b0},
            IDLE_O, IDLE_O, IDLE_O,
            {16'h7777, 2'b11, 1'b1, 1'b1, 1'b1},
            IDLE_O, IDLE_O };
        fifo_rdy = 1'b1; msg_in = 48'h010203040506; msg_len = 2'd3; v_msg_in = 1'b1;
        step();
        msg_in = 48'h0a0a0b0b0c0c;
        for (int i = 0; i < 9; i++) begin
            if (i < 3) begin
                v_msg_in = vin[i]; fifo_rdy = fr[i];
            end else if (i == 3) begin
                #2 rst = 1'b0;
            end else if (i == 5) begin
                rst = 1'b1; fifo_rdy = 1'b1; v_msg_in = 1'b1;
                msg_in = 48'h777700000000; msg_len = 2'd1;
            end else begin
                v_msg_in = 1'b0;
            end
            #1;
            vectors++;
            if (obs !== exp_o[i]) begin
                miscompares++;
                $display("FAIL reset_mid[%0d]: got %h expected %h", i, obs, exp_o[i]);
            end
            if (i != 3) step();
        end
    endtask

`ifdef FLIT_UPLOAD_LEN_CHECK_EN
    task automatic test_len_check();
        logic [21:0] exp_o [3] = '{ {IDLE_O, 1'b0}, {IDLE_O, 1'b1}, {IDLE_O, 1'b1} };
        fifo_rdy = 1'b1; msg_in = 48'hdeaddeaddead; msg_len = 2'd0; v_msg_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if ({obs, len_err} !== exp_o[i]) begin
                miscompares++;
                $display("FAIL len_check[%0d]: got %h expected %h", i, {obs, len_err}, exp_o[i]);
            end
            step();
            v_msg_in = 1'b0;
        end
    endtask
`endif

    initial begin
        rst = 1'b0; v_msg_in = 1'b0; fifo_rdy = 1'b0; msg_in = '0; msg_len = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_full_queue();
        test_short();
        test_reset_mid_message();
`ifdef FLIT_UPLOAD_LEN_CHECK_EN
        test_len_check();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
